// File: rtl/seg7_scan.sv
// Four-digit common-anode 7-segment scan driver with per-frame BCD snapshot.
// Optional leading-zero blanking is enabled by defining SEG7_LZB_EN.
module seg7_scan #(
    parameter int REFRESH_DIV = 100000,
    parameter int DP_DIGIT    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] s0,
    input  logic [3:0] s1,
    input  logic [3:0] s2,
    input  logic [3:0] s3,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);
    localparam int PW = $clog2(REFRESH_DIV);
    localparam logic [PW-1:0] TC_VAL = PW'(REFRESH_DIV - 1);

    logic [PW-1:0]   r_presc;
    logic [1:0]      r_idx;
    logic [3:0][3:0] r_snap;

    logic       w_tc;
    logic [3:0] w_digit;
    logic [6:0] w_dec;
    logic       w_blank;
    logic [3:0] w_an;
    logic       w_dp;

    assign w_tc    = (r_presc == TC_VAL);
    assign w_digit = r_snap[r_idx];
    assign w_an    = ~(4'b0001 << r_idx);
    assign w_dp    = (int'(r_idx) == DP_DIGIT) ? 1'b0 : 1'b1;

    always_comb begin
        w_dec = 7'b0111111;
        case (w_digit)
            4'd0: w_dec = 7'b1000000;
            4'd1: w_dec = 7'b1111001;
            4'd2: w_dec = 7'b0100100;
            4'd3: w_dec = 7'b0110000;
            4'd4: w_dec = 7'b0011001;
            4'd5: w_dec = 7'b0010010;
            4'd6: w_dec = 7'b0000010;
            4'd7: w_dec = 7'b1111000;
            4'd8: w_dec = 7'b0000000;
            4'd9: w_dec = 7'b0010000;
            default: w_dec = 7'b0111111;
        endcase
    end

`ifdef SEG7_LZB_EN
    // A digit blanks only if it and every more-significant digit are zero.
    always_comb begin
        w_blank = 1'b0;
        case (r_idx)
            2'd3: w_blank = (r_snap[3] == 4'd0);
            2'd2: w_blank = (r_snap[3] == 4'd0) && (r_snap[2] == 4'd0);
            2'd1: w_blank = (r_snap[3] == 4'd0) && (r_snap[2] == 4'd0) && (r_snap[1] == 4'd0);
            default: w_blank = 1'b0;
        endcase
    end
`else
    assign w_blank = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_presc <= '0;
            r_idx   <= 2'd0;
            r_snap  <= '0;
            an      <= 4'b1111;
            seg     <= 7'b1111111;
            dp      <= 1'b1;
        end else begin
            r_presc <= w_tc ? '0 : r_presc + 1'b1;
            if (w_tc) r_idx <= r_idx + 2'd1;
            // Frame boundary: latch all four digits at once so a frame is never torn.
            if (w_tc && r_idx == 2'd3) r_snap <= {s3, s2, s1, s0};
            an  <= w_an;
            seg <= w_blank ? 7'b1111111 : w_dec;
            dp  <= w_dp;
        end
    end
endmodule

// File: doc/seg7_scan.md
# seg7_scan

Time-multiplexed driver for a four-digit, common-anode seven-segment display. It sits directly downstream of the stopwatch BCD counter and takes its four digit outputs s0..s3. Each scan frame it snapshots the digits, so a count change mid-frame can never show as a torn value. It then strobes one digit at a time, decoding BCD to active-low segment patterns.

## Interface
- REFRESH_DIV, 100000: clk cycles each digit stays lit (must be ≥ 2); prescaler width is $clog2(REFRESH_DIV).
- DP_DIGIT, 2: digit index (0..3) whose decimal point is lit; 4 means no decimal point is lit.
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high.
- s0  input  4  BCD digit 0, the least significant digit (rightmost).
- s1  input  4  BCD digit 1.
- s2  input  4  BCD digit 2.
- s3  input  4  BCD digit 3, the most significant digit (leftmost).
- an  output  4  anode enables, active-low; an[i] selects digit i.
- seg  output  7  cathodes, active-low, ordered {g,f,e,d,c,b,a}.
- dp  output  1  decimal point cathode, active-low.

## Operation
- Prescaler: counts 0..REFRESH_DIV-1 and wraps to 0. Its terminal count (TC) is prescaler == REFRESH_DIV-1.
- Digit index: 2-bit register, sequence 0→1→2→3→0. It advances by one on each TC cycle and holds otherwise.
- Frame snapshot: snap[0..3] loads from s0..s3 on a cycle with TC and index == 3, which is the frame boundary. New values are displayed from digit 0 onward. Input changes at any other time have no effect until the next boundary.
- Decode of snap[index]:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Non-BCD values 10..15 show a dash, 0111111 (only g lit).
- an: an = ~(4'b0001 << index).
- dp: 0 when index == DP_DIGIT, else 1.
- Reset values:
  - prescaler 0, index 0, snap[0..3] 0.
  - an 4'b1111, seg 7'b1111111, dp 1 (display dark while reset is high).
- Reset mid-scan: takes effect at the next edge with reset high, overriding TC and the snapshot load. Scanning restarts at digit 0, and the displayed value is 0000 until the first frame boundary.

## Timing
- an, seg and dp are registered outputs. They reflect the index and snap values from the previous cycle, giving one cycle of latency.
- First edge with reset low: an=1110, seg=1000000 (digit 0 shows snap 0). dp=1, unless DP_DIGIT == 0, in which case dp=0.
- Each digit is shown for exactly REFRESH_DIV cycles; one frame is 4·REFRESH_DIV cycles.
- Snapshot latency: an input value present at the boundary edge reaches seg (on digit 0) two edges later.
- Simultaneous TC and reset: reset wins; no index advance and no snapshot load.
- Wrap-around: on TC with index == 3, the index returns to 0 and the snapshot loads on the same edge.

## Configuration
- SEG7_LZB_EN (leading-zero blanking):
  - Defined: on the digit-3 slot, seg=1111111 when snap[3]==0.
  - Defined: on the digit-2 slot, seg=1111111 when snap[3]==snap[2]==0.
  - Defined: on the digit-1 slot, seg=1111111 when snap[3..1] are all 0.
  - Defined: digit 0 is never blanked, the anode still strobes for blanked digits, and dp is unaffected by blanking.
  - Undefined: all four digits always show their decoded value.

## Test plan
- Reset: hold reset 3 cycles with inputs 9876 -> an=1111, seg=1111111, dp=1 throughout. Release -> an=1110, seg=1000000 on the next edge.
- Scan order (REFRESH_DIV=4): run 32 cycles -> an goes 1110, 1101, 1011, 0111, each for exactly 4 cycles, then repeats. dp=0 only while an=1011.
- Snapshot: inputs 1234 applied mid-frame -> display stays 0000 until the boundary. The next frame shows digit0=0011001 (4), digit1=0110000 (3), digit2=0100100 (2), digit3=1111001 (1). Changing the inputs to 5678 during that frame shows no change in it.
- Decode sweep: drive every value 0..15 on all digits, one per frame -> the table patterns appear, and 10..15 show 0111111.
- Reset mid-scan: assert reset while an=1011 -> next edge an=1111. After release, scanning restarts at an=1110 and seg shows 0.
- SEG7_LZB_EN defined, inputs 0007 -> digits 3..1 show seg=1111111 while their anodes still strobe, digit 0 shows 1111000. Inputs 0000 -> only digit 0 is lit, showing 1000000.
